// File: rtl/m2v_side_pkg.sv
// Shared definitions for the macroblock side-info queue: width defaults,
// block counts per chroma format, picture-field payload and record layout.
package m2v_side_pkg;

  localparam int unsigned MVH_WIDTH_DEF  = 16;
  localparam int unsigned MVV_WIDTH_DEF  = 15;
  localparam int unsigned MBX_WIDTH_DEF  = 6;
  localparam int unsigned MBY_WIDTH_DEF  = 5;
  localparam int unsigned DEPTH_LOG2_DEF = 2;

  localparam int unsigned NBLK_420       = 6;
  localparam int unsigned NBLK_422       = 8;
  localparam int unsigned QSCODE_WIDTH   = 5;
  localparam int unsigned PATTERN_WIDTH  = 8;

  // Picture-level fields as carried on s0_data[4:0] with pict_valid
  typedef struct packed {
    logic       chroma422;
    logic       iframe;
    logic       qstype;
    logic [1:0] dcprec;
  } pict_t;

  // Record field order, MSB first
  typedef enum logic [2:0] {
    FLD_MV_H, FLD_MV_V, FLD_MB_X, FLD_MB_Y,
    FLD_QSCODE, FLD_INTRA, FLD_PATTERN, FLD_CHROMA422
  } rec_field_e;

  function automatic int unsigned rec_width(input int unsigned mvh, input int unsigned mvv,
                                            input int unsigned mbx, input int unsigned mby);
    return mvh + mvv + mbx + mby + QSCODE_WIDTH + 1 + PATTERN_WIDTH + 1;
  endfunction

endpackage

// File: rtl/m2vside_qmem.sv
// Register-array FIFO of macroblock records with level, full and empty tracking.
module m2vside_qmem #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      wdata,
  output logic [WIDTH-1:0]      head_c,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  full,
  output logic                  empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned LVL_W = DEPTH_LOG2 + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr;
  logic [DEPTH_LOG2-1:0] rptr;
  logic [LVL_W-1:0]      level_nxt;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign head_c  = mem[rptr];

  always_comb begin
    level_nxt = level;
    if (flush) begin
      level_nxt = '0;
    end else if (do_push && !do_pop) begin
      level_nxt = level + LVL_W'(1);
    end else if (do_pop && !do_push) begin
      level_nxt = level - LVL_W'(1);
    end
  end

  // Full/empty are registered from the next level so s0_ready comes straight off a flop
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      level <= level_nxt;
      full  <= (level_nxt == LVL_W'(DEPTH));
      empty <= (level_nxt == '0);
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (do_push) wptr <= wptr + DEPTH_LOG2'(1);
        if (do_pop)  rptr <= rptr + DEPTH_LOG2'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

endmodule

// File: rtl/m2vside_queue.sv
// Macroblock side-info queue feeding per-block stage-1 outputs (4:2:0 and 4:2:2).
// Optional sticky overflow/underflow status enabled by M2VSIDEQ_STATUS_EN.
module m2vside_queue
  import m2v_side_pkg::*;
#(
  parameter int unsigned MVH_WIDTH  = MVH_WIDTH_DEF,
  parameter int unsigned MVV_WIDTH  = MVV_WIDTH_DEF,
  parameter int unsigned MBX_WIDTH  = MBX_WIDTH_DEF,
  parameter int unsigned MBY_WIDTH  = MBY_WIDTH_DEF,
  parameter int unsigned DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [MVH_WIDTH-1:0]    s0_data,
  input  logic                    pict_valid,
  input  logic                    mvec_h_valid,
  input  logic                    mvec_v_valid,
  input  logic                    s0_valid,
  input  logic [MBX_WIDTH-1:0]    s0_mb_x,
  input  logic [MBY_WIDTH-1:0]    s0_mb_y,
  input  logic [4:0]              s0_mb_qscode,
  output logic                    s0_ready,
  output logic [DEPTH_LOG2:0]     s0_level,
  input  logic                    flush,
  input  logic                    pre_block_start,
  output logic [1:0]              sa_dcprec,
  output logic                    sa_qstype,
  output logic                    sa_iframe,
  output logic                    sa_chroma422,
  output logic [MVH_WIDTH-1:0]    s1_mv_h,
  output logic [MVV_WIDTH-1:0]    s1_mv_v,
  output logic [MBX_WIDTH-1:0]    s1_mb_x,
  output logic [MBY_WIDTH-1:0]    s1_mb_y,
  output logic [4:0]              s1_mb_qscode,
  output logic                    s1_mb_intra,
  output logic [2:0]              s1_block,
  output logic                    s1_coded,
  output logic                    s1_enable,
  output logic                    s1_overflow,
  output logic                    s1_underflow
);

  localparam int unsigned REC_W = rec_width(MVH_WIDTH, MVV_WIDTH, MBX_WIDTH, MBY_WIDTH);

  pict_t                  pict_q;
  logic [MVH_WIDTH-1:0]   mv_h_q;
  logic [MVV_WIDTH-1:0]   mv_v_q;
  logic [2:0]             blk_cnt;

  logic [REC_W-1:0]       wr_rec;
  logic [REC_W-1:0]       head_rec;
  logic                   full;
  logic                   empty;
  logic                   push;
  logic                   pop;
  logic                   last_blk;
  logic                   advance;

  logic [MVH_WIDTH-1:0]   h_mv_h;
  logic [MVV_WIDTH-1:0]   h_mv_v;
  logic [MBX_WIDTH-1:0]   h_mb_x;
  logic [MBY_WIDTH-1:0]   h_mb_y;
  logic [4:0]             h_qscode;
  logic                   h_intra;
  logic [7:0]             h_pattern;
  logic                   h_chroma422;

  // Record takes the staged mv values and the chroma format in force at push time
  assign wr_rec = {mv_h_q, mv_v_q, s0_mb_x, s0_mb_y, s0_mb_qscode,
                   s0_data[8], s0_data[7:0], pict_q.chroma422};
  assign {h_mv_h, h_mv_v, h_mb_x, h_mb_y, h_qscode, h_intra, h_pattern, h_chroma422} = head_rec;

  assign last_blk = (blk_cnt == (h_chroma422 ? 3'(NBLK_422 - 1) : 3'(NBLK_420 - 1)));
  assign advance  = pre_block_start & ~empty & ~flush;
  assign push     = s0_valid & ~flush;
  assign pop      = advance & last_blk;
  assign s0_ready = ~full;

  assign sa_dcprec    = pict_q.dcprec;
  assign sa_qstype    = pict_q.qstype;
  assign sa_iframe    = pict_q.iframe;
  assign sa_chroma422 = pict_q.chroma422;

  m2vside_qmem #(
    .WIDTH      (REC_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_qmem (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .push    (push),
    .pop     (pop),
    .wdata   (wr_rec),
    .head_c  (head_rec),
    .level   (s0_level),
    .full    (full),
    .empty   (empty)
  );

  // Picture fields and mv staging survive flush
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pict_q <= '0;
      mv_h_q <= '0;
      mv_v_q <= '0;
    end else begin
      if (pict_valid)   pict_q <= pict_t'(s0_data[4:0]);
      if (mvec_h_valid) mv_h_q <= s0_data;
      if (mvec_v_valid) mv_v_q <= s0_data[MVV_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      blk_cnt      <= '0;
      s1_mv_h      <= '0;
      s1_mv_v      <= '0;
      s1_mb_x      <= '0;
      s1_mb_y      <= '0;
      s1_mb_qscode <= '0;
      s1_mb_intra  <= 1'b0;
      s1_block     <= '0;
      s1_coded     <= 1'b0;
      s1_enable    <= 1'b0;
    end else if (flush) begin
      blk_cnt   <= '0;
      s1_enable <= 1'b0;
    end else if (pre_block_start) begin
      if (!empty) begin
        s1_mv_h      <= h_mv_h;
        s1_mv_v      <= h_mv_v;
        s1_mb_x      <= h_mb_x;
        s1_mb_y      <= h_mb_y;
        s1_mb_qscode <= h_qscode;
        s1_mb_intra  <= h_intra;
        s1_block     <= blk_cnt;
        s1_coded     <= h_pattern[3'd7 - blk_cnt];
        s1_enable    <= 1'b1;
        blk_cnt      <= last_blk ? 3'd0 : blk_cnt + 3'd1;
      end else begin
        s1_enable <= 1'b0;
      end
    end
  end

`ifdef M2VSIDEQ_STATUS_EN
  // Sticky status, cleared only by flush or reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_overflow  <= 1'b0;
      s1_underflow <= 1'b0;
    end else if (flush) begin
      s1_overflow  <= 1'b0;
      s1_underflow <= 1'b0;
    end else begin
      if (s0_valid && full)         s1_overflow  <= 1'b1;
      if (pre_block_start && empty) s1_underflow <= 1'b1;
    end
  end
`else
  assign s1_overflow  = 1'b0;
  assign s1_underflow = 1'b0;
`endif

endmodule

// File: tb/tb_m2vside_queue.sv
// Scoreboard bench for m2vside_queue: stimulus queues expected stage-1 results,
// a negedge monitor compares them after every pre_block_start.
module tb_m2vside_queue;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] s0_data = '0;
  logic        pict_valid = 1'b0;
  logic        mvec_h_valid = 1'b0;
  logic        mvec_v_valid = 1'b0;
  logic        s0_valid = 1'b0;
  logic [5:0]  s0_mb_x = '0;
  logic [4:0]  s0_mb_y = '0;
  logic [4:0]  s0_mb_qscode = '0;
  logic        s0_ready;
  logic [2:0]  s0_level;
  logic        flush = 1'b0;
  logic        pre_block_start = 1'b0;
  logic [1:0]  sa_dcprec;
  logic        sa_qstype, sa_iframe, sa_chroma422;
  logic [15:0] s1_mv_h;
  logic [14:0] s1_mv_v;
  logic [5:0]  s1_mb_x;
  logic [4:0]  s1_mb_y;
  logic [4:0]  s1_mb_qscode;
  logic        s1_mb_intra;
  logic [2:0]  s1_block;
  logic        s1_coded, s1_enable, s1_overflow, s1_underflow;

  m2vside_queue dut (
    .clk(clk), .reset_n(reset_n), .s0_data(s0_data), .pict_valid(pict_valid),
    .mvec_h_valid(mvec_h_valid), .mvec_v_valid(mvec_v_valid), .s0_valid(s0_valid),
    .s0_mb_x(s0_mb_x), .s0_mb_y(s0_mb_y), .s0_mb_qscode(s0_mb_qscode),
    .s0_ready(s0_ready), .s0_level(s0_level), .flush(flush),
    .pre_block_start(pre_block_start), .sa_dcprec(sa_dcprec), .sa_qstype(sa_qstype),
    .sa_iframe(sa_iframe), .sa_chroma422(sa_chroma422), .s1_mv_h(s1_mv_h),
    .s1_mv_v(s1_mv_v), .s1_mb_x(s1_mb_x), .s1_mb_y(s1_mb_y),
    .s1_mb_qscode(s1_mb_qscode), .s1_mb_intra(s1_mb_intra), .s1_block(s1_block),
    .s1_coded(s1_coded), .s1_enable(s1_enable), .s1_overflow(s1_overflow),
    .s1_underflow(s1_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [2:0]  blk;
    logic        coded;
    logic [5:0]  mbx;
    logic [4:0]  mby;
    logic [15:0] mvh;
    logic        intra;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   failures = 0;
  logic pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  always @(posedge clk) pend <= pre_block_start && !flush && reset_n;

  // Monitor: one expectation per non-flushed pre_block_start
  always @(negedge clk) begin
    if (pend) begin
      if (expq.size() == 0) begin
        chk("scoreboard_underrun", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        chk("s1_enable", 32'(s1_enable), 32'(e.en));
        chk("s1_block",  32'(s1_block),  32'(e.blk));
        chk("s1_coded",  32'(s1_coded),  32'(e.coded));
        chk("s1_mb_x",   32'(s1_mb_x),   32'(e.mbx));
        chk("s1_mb_y",   32'(s1_mb_y),   32'(e.mby));
        chk("s1_mv_h",   32'(s1_mv_h),   32'(e.mvh));
        chk("s1_intra",  32'(s1_mb_intra), 32'(e.intra));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    pict_valid = 0; mvec_h_valid = 0; mvec_v_valid = 0;
    s0_valid = 0; flush = 0; pre_block_start = 0;
  endtask

  task automatic set_push(input int x, input int y, input logic [7:0] pat, input logic intra);
    s0_valid = 1; s0_mb_x = 6'(x); s0_mb_y = 5'(y); s0_mb_qscode = 5'(x);
    s0_data = {7'd0, intra, pat};
  endtask

  task automatic push_rec(input int x, input int y, input logic [7:0] pat, input logic intra);
    set_push(x, y, pat, intra);
    tick();
  endtask

  task automatic set_pbs(input logic en, input int blk, input logic coded, input int x,
                         input int y, input logic [15:0] mvh, input logic intra);
    exp_t e;
    e.en = en; e.blk = 3'(blk); e.coded = coded; e.mbx = 6'(x); e.mby = 5'(y);
    e.mvh = mvh; e.intra = intra;
    expq.push_back(e);
    pre_block_start = 1;
  endtask

  task automatic pbs(input logic en, input int blk, input logic coded, input int x,
                     input int y, input logic [15:0] mvh, input logic intra);
    set_pbs(en, blk, coded, x, y, mvh, intra);
    tick();
  endtask

  task automatic chk_flags(input logic ovf, input logic unf);
`ifdef M2VSIDEQ_STATUS_EN
    chk("s1_overflow", 32'(s1_overflow), 32'(ovf));
    chk("s1_underflow", 32'(s1_underflow), 32'(unf));
`else
    chk("s1_overflow_tied", 32'(s1_overflow), 32'(ovf & 1'b0));
    chk("s1_underflow_tied", 32'(s1_underflow), 32'(unf & 1'b0));
`endif
  endtask

  initial begin
    logic [7:0] pats [4];
    logic [7:0] p422;
    pats[0] = 8'hFC; pats[1] = 8'h00; pats[2] = 8'hFC; pats[3] = 8'hFC;
    p422 = 8'hA5;

    // Reset state
    #12;
    chk("rst_ready", 32'(s0_ready), 32'd1);
    chk("rst_level", 32'(s0_level), 32'd0);
    chk("rst_enable", 32'(s1_enable), 32'd0);
    chk("rst_dcprec", 32'(sa_dcprec), 32'd0);
    chk_flags(1'b0, 1'b0);
    reset_n = 1;

    // 1: picture fields, one 4:2:0 record, six blocks
    pict_valid = 1; s0_data = 16'h0005; tick();
    mvec_h_valid = 1; s0_data = 16'h1234; tick();
    push_rec(1, 2, 8'hFC, 1'b0);
    chk("t1_level", 32'(s0_level), 32'd1);
    for (int b = 0; b < 6; b++) pbs(1, b, 1, 1, 2, 16'h1234, 0);
    chk("t1_dcprec", 32'(sa_dcprec), 32'd1);
    chk("t1_qstype", 32'(sa_qstype), 32'd1);
    chk("t1_level_end", 32'(s0_level), 32'd0);

    // 2: fill to DEPTH, overflow drops the fifth push
    for (int k = 0; k < 4; k++) push_rec(10 + k, k, pats[k], k == 2);
    chk("t2_ready_full", 32'(s0_ready), 32'd0);
    chk("t2_level_full", 32'(s0_level), 32'd4);
    push_rec(14, 7, 8'hFC, 1'b0);
    chk("t2_level_drop", 32'(s0_level), 32'd4);
    chk_flags(1'b1, 1'b0);
    for (int k = 0; k < 4; k++)
      for (int b = 0; b < 6; b++)
        pbs(1, b, pats[k][7-b], 10 + k, k, 16'h1234, k == 2);
    // 5: underflow, stage-1 fields hold at last record (mb_x 13, never 14)
    pbs(0, 5, 1, 13, 3, 16'h1234, 0);
    chk_flags(1'b1, 1'b1);

    // 3: 4:2:2 record, mv update on the push cycle is not captured
    pict_valid = 1; s0_data = 16'h0015; tick();
    chk("t3_chroma422", 32'(sa_chroma422), 32'd1);
    set_push(20, 9, p422, 1'b0);
    mvec_h_valid = 1;
    tick();
    for (int b = 0; b < 7; b++) pbs(1, b, p422[7-b], 20, 9, 16'h1234, 0);
    chk("t3_level_b6", 32'(s0_level), 32'd1);
    pbs(1, 7, 1, 20, 9, 16'h1234, 0);
    chk("t3_level_b7", 32'(s0_level), 32'd0);

    // 4: push coincident with final-block pop
    pict_valid = 1; s0_data = 16'h0005; tick();
    push_rec(30, 1, 8'hFC, 1'b0);
    for (int b = 0; b < 5; b++) pbs(1, b, 1, 30, 1, 16'h00A5, 0);
    set_push(31, 3, 8'hFC, 1'b0);
    set_pbs(1, 5, 1, 30, 1, 16'h00A5, 0);
    tick();
    chk("t4_level_same", 32'(s0_level), 32'd1);
    for (int b = 0; b < 6; b++) pbs(1, b, 1, 31, 3, 16'h00A5, 0);
    chk("t4_level_end", 32'(s0_level), 32'd0);

    // 6: flush mid-record
    push_rec(40, 4, 8'hFC, 1'b0);
    push_rec(41, 5, 8'hFC, 1'b0);
    for (int b = 0; b < 3; b++) pbs(1, b, 1, 40, 4, 16'h00A5, 0);
    flush = 1; tick();
    chk("t6_level", 32'(s0_level), 32'd0);
    chk("t6_enable", 32'(s1_enable), 32'd0);
    chk("t6_ready", 32'(s0_ready), 32'd1);
    chk("t6_dcprec_kept", 32'(sa_dcprec), 32'd1);
    chk_flags(1'b0, 1'b0);
    push_rec(42, 6, 8'hFC, 1'b1);
    for (int b = 0; b < 6; b++) pbs(1, b, 1, 42, 6, 16'h00A5, 1);
    chk("t6_level_end", 32'(s0_level), 32'd0);

    tick(); tick();
    chk("scoreboard_drained", 32'(expq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
